// File: rtl/io_pwm_led.sv
// io_pwm_led: CH-channel memory-mapped PWM LED driver with shared prescaler, period-aligned duty shadows and load readback.
// Define IO_LED_BLINK_EN to add the BLINK register (per-channel mask + divider) and its period counter.
module io_pwm_led #(
  parameter int         CH       = 3,
  parameter int         PWM_W    = 8,
  parameter int         PRE_W    = 16,
  parameter logic [9:0] BASE_IDX = 10'h3F0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    st_we_io,
  input  logic [9:0]    st_adr_io,
  input  logic [31:0]   st_data_io,
  input  logic          ld_re_io,
  input  logic [9:0]    ld_adr_io,
  output logic [31:0]   ld_data_io,
  output logic [CH-1:0] led
);

  logic [1:0]       ctrl;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_reg [CH];
  logic [PWM_W-1:0] shadow   [CH];
  logic [PWM_W-1:0] duty_nxt [CH];

  logic [9:0]       st_rel;
  logic [9:0]       ld_rel;
  logic             wr;
  logic             wr_ctrl;
  logic             wr_pre;
  logic [CH-1:0]    wr_duty;
  logic [31:0]      bm;
  logic [31:0]      rd_data;
  logic [1:0]       ctrl_nxt;
  logic [PRE_W-1:0] pre_nxt;
  logic             tick;
  logic             period_start;
  logic [CH-1:0]    led_nxt;
  logic             unused_bits;

  // Byte-lane bit mask: each field keeps its old bits where the lane is not enabled.
  assign bm       = {{8{st_we_io[3]}}, {8{st_we_io[2]}}, {8{st_we_io[1]}}, {8{st_we_io[0]}}};
  assign st_rel   = st_adr_io - BASE_IDX;
  assign ld_rel   = ld_adr_io - BASE_IDX;
  assign wr       = |st_we_io;
  assign wr_ctrl  = wr && (st_rel == 10'd0);
  assign wr_pre   = wr && (st_rel == 10'd1);
  assign ctrl_nxt = (ctrl & ~bm[1:0]) | (st_data_io[1:0] & bm[1:0]);
  assign pre_nxt  = (prescale & ~bm[PRE_W-1:0]) | (st_data_io[PRE_W-1:0] & bm[PRE_W-1:0]);

  assign tick         = (pre_cnt == prescale);
  assign period_start = tick && (pwm_cnt == {PWM_W{1'b1}});

  // Field bits above each register's width are simply never stored.
  assign unused_bits  = ^{st_data_io, bm};

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      wr_duty[i]  = wr && (st_rel == 10'(2 + i));
      duty_nxt[i] = wr_duty[i]
                  ? ((duty_reg[i] & ~bm[PWM_W-1:0]) | (st_data_io[PWM_W-1:0] & bm[PWM_W-1:0]))
                  : duty_reg[i];
    end
  end

`ifdef IO_LED_BLINK_EN
  logic [CH-1:0] blink_mask;
  logic [CH-1:0] blink_mask_nxt;
  logic [3:0]    blink_div;
  logic [3:0]    blink_div_nxt;
  logic [15:0]   blink_cnt;
  logic          wr_blink;
  logic          blink_phase;

  assign wr_blink       = wr && (st_rel == 10'(2 + CH));
  assign blink_mask_nxt = (blink_mask & ~bm[CH-1:0]) | (st_data_io[CH-1:0] & bm[CH-1:0]);
  assign blink_div_nxt  = (blink_div & ~bm[11:8]) | (st_data_io[11:8] & bm[11:8]);
  assign blink_phase    = blink_cnt[blink_div];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_mask <= '0;
      blink_div  <= '0;
      blink_cnt  <= '0;
    end else begin
      if (wr_blink) begin
        blink_mask <= blink_mask_nxt;
        blink_div  <= blink_div_nxt;
      end
      if (period_start) blink_cnt <= blink_cnt + 16'd1;
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      led_nxt[i] = 1'b0;
      if (ctrl[0]) begin
        if (!ctrl[1]) led_nxt[i] = |duty_reg[i];
        else          led_nxt[i] = (&shadow[i]) || (pwm_cnt < shadow[i]);
      end
`ifdef IO_LED_BLINK_EN
      if (blink_mask[i] && blink_phase) led_nxt[i] = 1'b0;
`endif
    end
  end

  // Readback shows the programmed duty, not the shadow in use.
  always_comb begin
    rd_data = '0;
    if (ld_rel == 10'd0)      rd_data[1:0]       = ctrl;
    else if (ld_rel == 10'd1) rd_data[PRE_W-1:0] = prescale;
    for (int i = 0; i < CH; i++) begin
      if (ld_rel == 10'(2 + i)) rd_data[PWM_W-1:0] = duty_reg[i];
    end
`ifdef IO_LED_BLINK_EN
    if (ld_rel == 10'(2 + CH)) begin
      rd_data[CH-1:0] = blink_mask;
      rd_data[11:8]   = blink_div;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl       <= '0;
      prescale   <= '0;
      pre_cnt    <= '0;
      pwm_cnt    <= '0;
      led        <= '0;
      ld_data_io <= '0;
      for (int i = 0; i < CH; i++) begin
        duty_reg[i] <= '0;
        shadow[i]   <= '0;
      end
    end else begin
      if (wr_ctrl) ctrl     <= ctrl_nxt;
      if (wr_pre)  prescale <= pre_nxt;
      if (wr_pre || tick) pre_cnt <= '0;
      else                pre_cnt <= pre_cnt + PRE_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_W'(1);
      for (int i = 0; i < CH; i++) begin
        duty_reg[i] <= duty_nxt[i];
        if (period_start) shadow[i] <= duty_nxt[i];
      end
      led <= led_nxt;
      if (ld_re_io) ld_data_io <= rd_data;
    end
  end

endmodule

// File: tb/tb_io_pwm_led.sv
// tb_io_pwm_led: directed stimulus against a period/tick-count model of the LED driver, compared every cycle.
// Define IO_LED_BLINK_EN to include the blink scenario.
module tb_io_pwm_led;
  localparam int         CH   = 3;
  localparam logic [9:0] BASE = 10'h3F0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    st_we_io;
  logic [9:0]    st_adr_io;
  logic [31:0]   st_data_io;
  logic          ld_re_io;
  logic [9:0]    ld_adr_io;
  logic [31:0]   ld_data_io;
  logic [CH-1:0] led;

  always #5 clk = ~clk;

  io_pwm_led #(.CH(CH), .PWM_W(8), .PRE_W(16), .BASE_IDX(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .st_we_io(st_we_io), .st_adr_io(st_adr_io),
    .st_data_io(st_data_io), .ld_re_io(ld_re_io), .ld_adr_io(ld_adr_io),
    .ld_data_io(ld_data_io), .led(led)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: registers as programmed, total ticks since reset; pwm position and period number follow arithmetically.
  logic [1:0]    m_ctrl;
  logic [15:0]   m_pre;
  int            m_acc;
  int            m_ticks;
  logic [7:0]    m_duty [CH];
  logic [7:0]    m_act  [CH];
  logic [CH-1:0] m_bmask;
  logic [3:0]    m_bdiv;
  logic [CH-1:0] exp_led;
  logic [31:0]   exp_ld;
  bit            m_valid;

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be, input logic [31:0] fmask);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r & fmask;
  endfunction

  function automatic logic [31:0] m_read(input logic [9:0] idx);
    logic [31:0] r;
    r = '0;
    if (idx == 10'd0) r = {30'd0, m_ctrl};
    else if (idx == 10'd1) r = {16'd0, m_pre};
    else if (idx >= 10'd2 && idx < 10'(2 + CH)) r = {24'd0, m_duty[idx - 10'd2]};
`ifdef IO_LED_BLINK_EN
    else if (idx == 10'(2 + CH)) r = {20'd0, m_bdiv, 5'd0, m_bmask};
`endif
    return r;
  endfunction

  task automatic model_step();
    logic        tick;
    logic [9:0]  idx;
    logic [31:0] v;
    int          pos;
    int          per;
    if (!rst_n) begin
      m_ctrl = '0; m_pre = '0; m_acc = 0; m_ticks = 0; m_bmask = '0; m_bdiv = '0;
      for (int i = 0; i < CH; i++) begin m_duty[i] = '0; m_act[i] = '0; end
      exp_led = '0; exp_ld = '0; m_valid = 1'b1;
    end else begin
      tick = (m_acc == int'(m_pre));
      pos  = m_ticks % 256;
      per  = m_ticks / 256;
      for (int i = 0; i < CH; i++) begin
        if (!m_ctrl[0])      exp_led[i] = 1'b0;
        else if (!m_ctrl[1]) exp_led[i] = (m_duty[i] != 8'd0);
        else                 exp_led[i] = (m_act[i] == 8'hFF) || (pos < int'(m_act[i]));
`ifdef IO_LED_BLINK_EN
        if (m_bmask[i] && (((per >> m_bdiv) & 1) != 0)) exp_led[i] = 1'b0;
`endif
      end
      if (ld_re_io) exp_ld = m_read(ld_adr_io - BASE);
      if (tick) m_acc = 0; else m_acc++;
      idx = st_adr_io - BASE;
      if (|st_we_io) begin
        if (idx == 10'd0) begin
          v = lanes(m_read(idx), st_data_io, st_we_io, 32'h3);    m_ctrl = v[1:0];
        end else if (idx == 10'd1) begin
          v = lanes(m_read(idx), st_data_io, st_we_io, 32'hFFFF); m_pre = v[15:0]; m_acc = 0;
        end else if (idx >= 10'd2 && idx < 10'(2 + CH)) begin
          v = lanes(m_read(idx), st_data_io, st_we_io, 32'hFF);   m_duty[idx - 10'd2] = v[7:0];
        end
`ifdef IO_LED_BLINK_EN
        else if (idx == 10'(2 + CH)) begin
          v = lanes(m_read(idx), st_data_io, st_we_io, 32'h0F07); m_bmask = v[CH-1:0]; m_bdiv = v[11:8];
        end
`endif
      end
      if (tick) begin
        m_ticks++;
        if (m_ticks % 256 == 0) for (int i = 0; i < CH; i++) m_act[i] = m_duty[i];
      end
    end
  endtask

  initial begin
    m_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("led", 32'(led), 32'(exp_led));
        check("ld_data", ld_data_io, exp_ld);
      end
      model_step();
    end
  end

  task automatic wr(input logic [9:0] idx, input logic [31:0] d, input logic [3:0] be);
    st_adr_io = BASE + idx; st_data_io = d; st_we_io = be;
    @(posedge clk); #1;
    st_we_io = 4'h0;
  endtask

  task automatic rd(input logic [9:0] idx, output logic [31:0] d);
    ld_adr_io = BASE + idx; ld_re_io = 1'b1;
    @(posedge clk); #1;
    ld_re_io = 1'b0;
    d = ld_data_io;
  endtask

  task automatic count_high(input int n, output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    repeat (n) begin
      @(posedge clk); #1;
      c0 += int'(led[0]); c1 += int'(led[1]); c2 += int'(led[2]);
    end
  endtask

  logic [31:0] d;
  int c0, c1, c2;

  initial begin
    rst_n = 1'b0; st_we_io = '0; st_adr_io = '0; st_data_io = '0; ld_re_io = 1'b0; ld_adr_io = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_led", 32'(led), 32'd0);
    rst_n = 1'b1;
    rd(10'd0, d); check("reset_ctrl", d, 32'd0);
    rd(10'd2, d); check("reset_duty0", d, 32'd0);

    // PWM mode, tick every cycle, three duty settings.
    wr(10'd0, 32'h3, 4'hF);
    wr(10'd1, 32'h0, 4'hF);
    wr(10'd2, 32'h40, 4'hF);
    wr(10'd3, 32'hFF, 4'hF);
    wr(10'd4, 32'h0, 4'hF);
    repeat (600) @(posedge clk);
    #1;
    count_high(256, c0, c1, c2);
    check("duty40_high", c0, 64);
    check("dutyFF_high", c1, 256);
    check("duty00_high", c2, 0);

    // Duty change mid-period takes effect from the next period.
    repeat (37) @(posedge clk);
    #1;
    wr(10'd2, 32'hC0, 4'hF);
    repeat (256) @(posedge clk);
    #1;
    count_high(256, c0, c1, c2);
    check("dutyC0_high", c0, 192);

    // Static mode: led follows duty!=0 two edges after the store.
    wr(10'd0, 32'h1, 4'hF);
    wr(10'd4, 32'h1, 4'hF);
    check("static_before", 32'(led[2]), 32'd0);
    @(posedge clk); #1;
    check("static_on", 32'(led[2]), 32'd1);

    // Byte-lane store and field truncation.
    wr(10'd1, 32'h0000_AB12, 4'b0010);
    rd(10'd1, d); check("prescale_lane", d, 32'h0000_AB00);
    wr(10'd0, 32'hFFFF_FFFF, 4'hF);
    rd(10'd0, d); check("ctrl_trunc", d, 32'h3);
    wr(10'd5, 32'h0000_0A04, 4'hF);
    rd(10'd5, d);
`ifdef IO_LED_BLINK_EN
    check("blink_reg", d, 32'h0000_0A04);
`else
    check("unmapped_5", d, 32'h0);
`endif
    rd(10'd7, d); check("unmapped_7", d, 32'h0);

    // Store and load of the same register in one cycle returns the old value.
    st_adr_io = BASE + 10'd2; st_data_io = 32'h55; st_we_io = 4'hF;
    ld_adr_io = BASE + 10'd2; ld_re_io = 1'b1;
    @(posedge clk); #1;
    st_we_io = 4'h0; ld_re_io = 1'b0;
    check("same_idx_old", ld_data_io, 32'hC0);
    rd(10'd2, d); check("same_idx_new", d, 32'h55);

    // Reset in the middle of a running period.
    wr(10'd1, 32'h0, 4'hF);
    wr(10'd0, 32'h3, 4'hF);
    repeat (300) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_led", 32'(led), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(10'd2, d); check("midreset_duty0", d, 32'd0);

`ifdef IO_LED_BLINK_EN
    // Blink channel 0 with divider 0: on and off alternate per period.
    wr(10'd0, 32'h3, 4'hF);
    wr(10'd2, 32'hFF, 4'hF);
    wr(10'd3, 32'hFF, 4'hF);
    wr(10'd5, 32'h1, 4'hF);
    repeat (600) @(posedge clk);
    #1;
    count_high(512, c0, c1, c2);
    check("blink_ch0", c0, 256);
    check("blink_ch1", c1, 512);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
